// File: rtl/usb_in_ep_packetizer_if.sv
// Stream-side and protocol-engine-side signals of the bulk IN packetizer.
// The slave modport is the packetizer's view; master is the surrounding logic.
interface usb_in_ep_packetizer_if #(
    parameter int DEPTH = 128
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          flush;
    logic          stall_req;
    logic [LW-1:0] level;
    logic          in_ep_req;
    logic          in_ep_grant;
    logic          in_ep_data_free;
    logic          in_ep_data_put;
    logic [7:0]    in_ep_data;
    logic          in_ep_data_done;
    logic          in_ep_stall;
    logic          in_ep_acked;

    modport master (
        output s_data, s_valid, flush, stall_req,
        output in_ep_grant, in_ep_data_free, in_ep_acked,
        input  s_ready, level, in_ep_req, in_ep_data_put,
        input  in_ep_data, in_ep_data_done, in_ep_stall
    );

    modport slave (
        input  s_data, s_valid, flush, stall_req,
        input  in_ep_grant, in_ep_data_free, in_ep_acked,
        output s_ready, level, in_ep_req, in_ep_data_put,
        output in_ep_data, in_ep_data_done, in_ep_stall
    );
endinterface

// File: rtl/usb_in_ep_packetizer.sv
// Bulk IN endpoint producer: FWFT byte FIFO feeding max-packet-size
// transfers into the PE IN endpoint slot, with flush / ZLP termination.
module usb_in_ep_packetizer #(
    parameter int MAX_PKT = 64,
    parameter int DEPTH   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    usb_in_ep_packetizer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [6:0]    MAXC = 7'(MAX_PKT);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] PKTL = LW'(MAX_PKT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        WAIT_ACK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          r_s_ready;
    logic [6:0]    r_pkt_cnt;
    logic [6:0]    w_cnt_nxt;
    logic          r_flush_pend;
    logic          w_flush_nxt;
    logic          r_zlp_pend;
    logic          w_zlp_nxt;
    logic          r_req;
    logic          r_done;
    logic          r_stall;
    logic          w_push;
    logic          w_pop;
    logic          w_full_pkt;
    logic          w_ack;
    logic          w_end_nxt;

    assign w_push = bus.s_valid && r_s_ready;
    assign w_pop  = (r_state == FILL) && bus.in_ep_data_free &&
                    (r_level != '0) && (r_pkt_cnt < MAXC) &&
                    !r_zlp_pend;
    assign w_full_pkt = (r_pkt_cnt == MAXC);
    assign w_ack      = (r_state == WAIT_ACK) && bus.in_ep_acked;

    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_cnt_nxt   = w_ack ? 7'd0 : r_pkt_cnt + 7'(w_pop);

    // A short packet or ZLP that completes retires the pending flush
    always_comb begin
        w_flush_nxt = r_flush_pend;
        if (bus.flush)
            w_flush_nxt = 1'b1;
        else if (r_done && !w_full_pkt)
            w_flush_nxt = 1'b0;
    end

    always_comb begin
        w_zlp_nxt = r_zlp_pend;
        if (w_ack)
            w_zlp_nxt = w_full_pkt && (r_flush_pend || bus.flush) &&
                        (r_level == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:
                if (r_level >= PKTL || r_zlp_pend ||
                    (r_flush_pend && r_level != '0))
                    w_state_nxt = REQ;
            REQ:
                if (bus.in_ep_grant)
                    w_state_nxt = FILL;
            FILL:
                if (r_done)
                    w_state_nxt = WAIT_ACK;
            WAIT_ACK:
                if (bus.in_ep_acked)
                    w_state_nxt = IDLE;
            default:
                w_state_nxt = IDLE;
        endcase
    end

    // Done is registered one cycle ahead so it lands right after the last put
    assign w_end_nxt = (w_state_nxt == FILL) &&
                       (r_zlp_pend || w_cnt_nxt == MAXC ||
                        (w_flush_nxt && w_level_nxt == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_s_ready    <= 1'b1;
            r_pkt_cnt    <= '0;
            r_flush_pend <= 1'b0;
            r_zlp_pend   <= 1'b0;
            r_req        <= 1'b0;
            r_done       <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_s_ready    <= (w_level_nxt != FULL);
            r_pkt_cnt    <= w_cnt_nxt;
            r_flush_pend <= w_flush_nxt;
            r_zlp_pend   <= w_zlp_nxt;
            r_req        <= (w_state_nxt != IDLE);
            r_done       <= w_end_nxt;
            r_stall      <= bus.stall_req;
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus.s_data;
    end

    assign bus.s_ready         = r_s_ready;
    assign bus.level           = r_level;
    assign bus.in_ep_req       = r_req;
    assign bus.in_ep_data_put  = w_pop;
    assign bus.in_ep_data      = r_mem[r_rptr];
    assign bus.in_ep_data_done = r_done;
    assign bus.in_ep_stall     = r_stall;
endmodule

// File: tb/tb_usb_in_ep_packetizer.sv
// Bench for usb_in_ep_packetizer: packet scenarios from a table,
// byte ordering via a push/put scoreboard, plus reset and stall sequences.
module tb_usb_in_ep_packetizer;
    typedef struct packed {
        logic [7:0]      n;
        logic            fl;
        logic            tog;
        logic            hold;
        logic [1:0]      npk;
        logic [2:0][7:0] sz;
        logic            full;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int put_cnt = 0;
    int done_cnt = 0;
    int tx_id = 0;
    int saw_full = 0;
    logic [7:0] sb_q [$];
    vec_t vt [4];
    vec_t v_rst;
    vec_t v_tail;

    usb_in_ep_packetizer_if #(.DEPTH(128)) bus ();

    usb_in_ep_packetizer #(.MAX_PKT(64), .DEPTH(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fail_to(input string nm);
        n_chk++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Sample just before each rising edge what the DUT will do at that edge
    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            if (bus.s_valid && bus.s_ready)
                sb_q.push_back(bus.s_data);
            if (bus.level == 128 && !bus.s_ready)
                saw_full = 1;
            if (bus.in_ep_data_put) begin
                check("put_free", int'(bus.in_ep_data_free), 1);
                if (sb_q.size() == 0)
                    fail_to("put_without_byte");
                else
                    check("put_data", int'(bus.in_ep_data),
                          int'(sb_q.pop_front()));
                put_cnt++;
            end
            if (bus.in_ep_data_done)
                done_cnt++;
        end
    end

    task automatic push_bytes(input int n, input bit fl);
        int sent = 0;
        int t = 0;
        while (sent < n && t < 5000) begin
            if (bus.s_ready) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'(tx_id);
                tx_id++;
                sent++;
            end else begin
                bus.s_valid = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        bus.s_valid = 1'b0;
        if (sent < n)
            fail_to("push");
        if (fl) begin
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end
    endtask

    task automatic wait_req(output bit ok);
        int t = 0;
        while (!bus.in_ep_req && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = bus.in_ep_req;
    endtask

    task automatic serve(input vec_t v);
        int p0;
        int d0;
        int t;
        bit ok;
        for (int k = 0; k < int'(v.npk); k++) begin
            wait_req(ok);
            if (!ok) begin
                fail_to("req");
                return;
            end
            if (k == 0 && v.hold) begin
                t = 0;
                while (bus.s_ready && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                if (bus.s_ready) begin
                    fail_to("fifo_full");
                    return;
                end
            end
            bus.in_ep_grant = 1'b1;
            @(negedge clk);
            bus.in_ep_grant = 1'b0;
            p0 = put_cnt;
            d0 = done_cnt;
            t = 0;
            while (done_cnt == d0 && t < 3000) begin
                if (v.tog)
                    bus.in_ep_data_free = !bus.in_ep_data_free;
                @(negedge clk);
                t++;
            end
            bus.in_ep_data_free = 1'b1;
            if (done_cnt == d0) begin
                fail_to("data_done");
                return;
            end
            check("pkt_size", put_cnt - p0, int'(v.sz[k]));
            repeat (3) @(negedge clk);
            check("wait_no_put", put_cnt - p0, int'(v.sz[k]));
            check("one_done", done_cnt - d0, 1);
            check("req_held", int'(bus.in_ep_req), 1);
            bus.in_ep_acked = 1'b1;
            @(negedge clk);
            bus.in_ep_acked = 1'b0;
            check("req_drop", int'(bus.in_ep_req), 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        tx_id = 0;
        saw_full = 0;
        fork
            push_bytes(int'(v.n), v.fl);
            serve(v);
        join
        @(negedge clk);
        check("level_end", int'(bus.level), 0);
        check("sb_empty", sb_q.size(), 0);
        check("saw_full", saw_full, int'(v.full));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, int'(bus.s_ready), 1);
        check({tag, "_level"}, int'(bus.level), 0);
        check({tag, "_req"}, int'(bus.in_ep_req), 0);
        check({tag, "_put"}, int'(bus.in_ep_data_put), 0);
        check({tag, "_done"}, int'(bus.in_ep_data_done), 0);
        check({tag, "_stall"}, int'(bus.in_ep_stall), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        int t;
        bit ok;

        vt[0] = '{n: 8'd64, fl: 1'b0, tog: 1'b0, hold: 1'b0, npk: 2'd1,
                  sz: {8'd0, 8'd0, 8'd64}, full: 1'b0};
        vt[1] = '{n: 8'd5, fl: 1'b1, tog: 1'b0, hold: 1'b0, npk: 2'd1,
                  sz: {8'd0, 8'd0, 8'd5}, full: 1'b0};
        vt[2] = '{n: 8'd64, fl: 1'b1, tog: 1'b0, hold: 1'b0, npk: 2'd2,
                  sz: {8'd0, 8'd0, 8'd64}, full: 1'b0};
        vt[3] = '{n: 8'd130, fl: 1'b1, tog: 1'b1, hold: 1'b1, npk: 2'd3,
                  sz: {8'd2, 8'd64, 8'd64}, full: 1'b1};
        v_rst = vt[0];
        v_tail = vt[1];

        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.flush = 1'b0;
        bus.stall_req = 1'b0;
        bus.in_ep_grant = 1'b0;
        bus.in_ep_data_free = 1'b1;
        bus.in_ep_acked = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_vec(vt[i]);

        tx_id = 0;
        p0 = put_cnt;
        fork
            push_bytes(64, 1'b0);
            begin
                wait_req(ok);
                if (!ok) begin
                    fail_to("midfill_req");
                end else begin
                    bus.in_ep_grant = 1'b1;
                    @(negedge clk);
                    bus.in_ep_grant = 1'b0;
                    p0 = put_cnt;
                    t = 0;
                    while (put_cnt - p0 < 20 && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                end
            end
        join
        check("puts_before_reset", put_cnt - p0, 20);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midfill");
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        run_vec(v_rst);

        check("stall_pre", int'(bus.in_ep_stall), 0);
        bus.stall_req = 1'b1;
        @(negedge clk);
        check("stall_follow", int'(bus.in_ep_stall), 1);
        bus.stall_req = 1'b0;
        @(negedge clk);
        check("stall_clear", int'(bus.in_ep_stall), 0);

        d0 = done_cnt;
        bus.in_ep_acked = 1'b1;
        @(negedge clk);
        bus.in_ep_acked = 1'b0;
        check("spur_ack_req", int'(bus.in_ep_req), 0);
        @(negedge clk);
        check("spur_ack_req2", int'(bus.in_ep_req), 0);
        check("spur_ack_level", int'(bus.level), 0);
        check("spur_ack_done", done_cnt - d0, 0);
        run_vec(v_tail);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_in_ep_packetizer.md
# usb_in_ep_packetizer

Bulk IN endpoint producer for the full-speed USB stack. It accepts a byte stream from user logic, buffers it in an internal FIFO and packetizes it into max-packet-size transfers. It delivers each packet through the protocol engine's IN endpoint interface and waits for the host ACK before starting the next. It sits beside `usb_serial_ctrl_ep` as an additional IN endpoint slot on `usb_fs_pe`; the protocol engine owns packet storage and retransmission.

## Interface
- `MAX_PKT`, 64: maximum packet payload in bytes, 8..64.
- `DEPTH`, 128: FIFO depth in bytes; power of 2, ≥ `MAX_PKT`.
- `clk`  in  1  48 MHz clock (`clk_48mhz` domain).
- `reset`  in  1  synchronous, active-high.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO not full; a byte is accepted when `s_valid && s_ready`.
- `flush`  in  1  one-cycle pulse: send buffered bytes now, and terminate the transfer.
- `stall_req`  in  1  level: endpoint halted.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `in_ep_req`  out  1  request endpoint ownership.
- `in_ep_grant`  in  1  arbiter grant.
- `in_ep_data_free`  in  1  PE buffer can take a byte this cycle.
- `in_ep_data_put`  out  1  write strobe.
- `in_ep_data`  out  8  byte written.
- `in_ep_data_done`  out  1  one-cycle pulse: packet complete, arm for IN token.
- `in_ep_stall`  out  1  registered copy of `stall_req`.
- `in_ep_acked`  in  1  one-cycle pulse: host ACKed the packet.

## Operation
- FIFO is first-word-fall-through. `in_ep_data` always shows the FIFO head.
- Push and pop in the same cycle are allowed. `level` is unchanged when both occur.
- A push is accepted when full only if a pop occurs in the same cycle is false: `s_ready = !full`, registered from the previous `level`.
- `flush` sets `flush_pend`. `flush_pend` clears when a short packet (< `MAX_PKT`) or a ZLP gets `data_done`.
- `zlp_pend` is set on the ACK of a full packet when `flush_pend` is set and `level == 0`.
- FSM states:
  - IDLE → REQ when `level ≥ MAX_PKT`, or `flush_pend && level > 0`, or `zlp_pend`.
  - REQ: `in_ep_req = 1`. Moves to FILL on `in_ep_grant`.
  - FILL: `in_ep_req = 1`.
    - `in_ep_data_put = data_free && level > 0 && pkt_cnt < MAX_PKT && !zlp_pend`.
    - Each put pops the FIFO and increments `pkt_cnt` (7 bits).
    - Packet ends when `pkt_cnt == MAX_PKT`, or `level == 0` with `flush_pend`, or immediately when `zlp_pend`.
    - At packet end, pulse `data_done` and move to WAIT_ACK.
  - WAIT_ACK: `in_ep_req = 1`. On `in_ep_acked`, go to IDLE, clear `pkt_cnt`, clear `zlp_pend` if it was a ZLP, and evaluate the ZLP rule.
- Bytes arriving during FILL join the current packet up to `MAX_PKT`.
- `data_free` low during FILL holds the FSM with no put. It may toggle arbitrarily.
- `in_ep_acked` outside WAIT_ACK is ignored.
- `flush` during FILL or WAIT_ACK is latched and applied to the current packet if still in FILL, otherwise to the next.
- `stall_req` does not alter the FSM. The PE returns STALL, and no ACK arrives until it clears.
- Reset at any point:
  - FIFO emptied, `level = 0`, `s_ready = 1`.
  - FSM to IDLE, all flags cleared.
  - `in_ep_req`, `in_ep_data_put`, `in_ep_data_done` and `in_ep_stall` all 0.

## Timing
- Reset values:
  - `s_ready = 1`, `level = 0`.
  - `in_ep_req = 0`, `in_ep_data_put = 0`, `in_ep_data_done = 0`, `in_ep_stall = 0`.
  - `in_ep_data` is don't-care.
- Push to visible `level`: 1 cycle.
- IDLE→REQ: 1 cycle after the trigger condition.
- Grant→first put: 1 cycle (FILL entry), provided `data_free` is high.
- Throughput: 1 byte per cycle in FILL.
- `data_done` is asserted the cycle after the last put. `in_ep_req` remains high through that cycle.
- `in_ep_acked`→IDLE: 1 cycle. The next REQ can begin the cycle after that.
- `in_ep_stall` follows `stall_req` with 1-cycle latency.

## Test plan
- Push 64 bytes 0x00..0x3F with `data_free` high → `in_ep_req`; grant → 64 puts of 0x00..0x3F, then one `data_done`. No second REQ until `acked`.
- Push 5 bytes, then `flush` → 5-byte packet. `flush_pend` clears. No ZLP follows.
- Push 64 bytes plus `flush`, then ACK → a second packet with 0 puts and `data_done` (ZLP). ACK → IDLE, `level = 0`.
- Push 130 bytes with `DEPTH=128` → `s_ready` low at 128. Draining two 64-byte packets, with `data_free` toggling 1-0-1 every cycle → all bytes arrive in order, no put while `data_free` is low.
- Assert `reset` mid-FILL after 20 puts → the next cycle all outputs are at reset values and `level = 0`. A fresh 64-byte push yields a normal packet.
- Raise `stall_req` → `in_ep_stall` is 1 one cycle later. A spurious `acked` in IDLE → no state change.
